// File: rtl/route_demux_pkg.sv
// Shared constants and helpers for route_demux: port count, destination field layout,
// and the counter saturation limit.
package route_demux_pkg;

  localparam int unsigned PORTS  = 4;
  localparam int unsigned SEL_W  = 2;
  localparam int unsigned DEST_W = 2;

  // Destination field occupies the top DEST_W bits of a word.
  function automatic int unsigned dest_msb(input int unsigned data_w);
    return data_w - 1;
  endfunction

  function automatic int unsigned dest_lsb(input int unsigned data_w);
    return data_w - DEST_W;
  endfunction

  function automatic logic [31:0] sat_limit(input int unsigned cnt_w);
    return (cnt_w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << cnt_w) - 32'd1);
  endfunction

endpackage

// File: rtl/route_demux_sat_counter.sv
// Saturating up-counter with synchronous active-low reset; used for all route_demux statistics.
module sat_counter
  import route_demux_pkg::*;
#(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(sat_limit(CNT_W));

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt <= '0;
    end else if (inc && (cnt != CNT_MAX)) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/route_demux.sv
// Routes the word read from the arbiter-selected input FIFO to output FIFO P0..P3 by its
// destination field. Optional parity drop path enabled by PARITY_CHECK_EN.
module route_demux
  import route_demux_pkg::*;
#(
  parameter int unsigned DATA_W = 10,
  parameter int unsigned CNT_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [SEL_W-1:0]  select,
  input  logic              pop_F0,
  input  logic              pop_F1,
  input  logic              pop_F2,
  input  logic              pop_F3,
  input  logic [DATA_W-1:0] data_F0,
  input  logic [DATA_W-1:0] data_F1,
  input  logic [DATA_W-1:0] data_F2,
  input  logic [DATA_W-1:0] data_F3,
  input  logic              almost_full_P0,
  input  logic              almost_full_P1,
  input  logic              almost_full_P2,
  input  logic              almost_full_P3,
  output logic              push_P0,
  output logic              push_P1,
  output logic              push_P2,
  output logic              push_P3,
  output logic [DATA_W-1:0] data_out,
  output logic [CNT_W-1:0]  cnt_P0,
  output logic [CNT_W-1:0]  cnt_P1,
  output logic [CNT_W-1:0]  cnt_P2,
  output logic [CNT_W-1:0]  cnt_P3,
  output logic [CNT_W-1:0]  drop_cnt,
  output logic              idle
`ifdef PARITY_CHECK_EN
  , output logic            perr
`endif
);

  localparam int unsigned DMSB = dest_msb(DATA_W);
  localparam int unsigned DLSB = dest_lsb(DATA_W);

  logic              va;
  logic              vb;
  logic [SEL_W-1:0]  src_a;
  logic [PORTS-1:0]  pop_v;
  logic [PORTS-1:0]  af_v;
  logic [PORTS-1:0]  push_n;
  logic [PORTS-1:0]  push_q;
  logic [DATA_W-1:0] data_v [PORTS];
  logic [DATA_W-1:0] word_n;
  logic [DEST_W-1:0] dest_n;
  logic              par_bad_n;
  logic              keep_n;
  logic              drop_n;
  logic [CNT_W-1:0]  cnt_v [PORTS];

  assign pop_v     = {pop_F3, pop_F2, pop_F1, pop_F0};
  assign af_v      = {almost_full_P3, almost_full_P2, almost_full_P1, almost_full_P0};
  assign data_v[0] = data_F0;
  assign data_v[1] = data_F1;
  assign data_v[2] = data_F2;
  assign data_v[3] = data_F3;

  // Stage B source mux: select captured with the pop picks the FIFO read port.
  assign word_n = data_v[src_a];
  assign dest_n = word_n[DMSB:DLSB];

`ifdef PARITY_CHECK_EN
  assign par_bad_n = ^word_n;
`else
  assign par_bad_n = 1'b0;
`endif

  assign keep_n = va & ~af_v[dest_n] & ~par_bad_n;
  assign drop_n = va & ~keep_n;

  always_comb begin
    push_n = '0;
    if (keep_n) push_n[dest_n] = 1'b1;
  end

  // Stage A/B valid pipeline and registered push/data outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      va       <= 1'b0;
      vb       <= 1'b0;
      src_a    <= '0;
      push_q   <= '0;
      data_out <= '0;
    end else begin
      va     <= |pop_v;
      src_a  <= select;
      vb     <= va;
      push_q <= push_n;
      if (keep_n) data_out <= word_n;
    end
  end

`ifdef PARITY_CHECK_EN
  always_ff @(posedge clk) begin
    if (!reset) perr <= 1'b0;
    else        perr <= va & par_bad_n;
  end
`endif

  assign {push_P3, push_P2, push_P1, push_P0} = push_q;
  assign idle = ~va & ~vb;

  for (genvar i = 0; i < PORTS; i++) begin : g_cnt
    sat_counter #(.CNT_W(CNT_W)) u_cnt (
      .clk   (clk),
      .reset (reset),
      .inc   (push_n[i]),
      .cnt   (cnt_v[i])
    );
  end

  sat_counter #(.CNT_W(CNT_W)) u_drop (
    .clk   (clk),
    .reset (reset),
    .inc   (drop_n),
    .cnt   (drop_cnt)
  );

  assign cnt_P0 = cnt_v[0];
  assign cnt_P1 = cnt_v[1];
  assign cnt_P2 = cnt_v[2];
  assign cnt_P3 = cnt_v[3];

endmodule

// File: tb/tb_route_demux.sv
// Self-checking bench for route_demux: directed scenarios plus randomized traffic
// against a transaction-level reference model. Honours PARITY_CHECK_EN.
`timescale 1ns/1ps
module tb_route_demux;

  localparam int unsigned DATA_W = 10;
  localparam int unsigned CNT_W  = 8;
  localparam int          CNT_MAX = 255;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic [1:0]        select = '0;
  logic [3:0]        pop = '0;
  logic [3:0]        af = '0;
  logic [DATA_W-1:0] dat [4];
  logic              push_P0, push_P1, push_P2, push_P3;
  logic [DATA_W-1:0] data_out;
  logic [CNT_W-1:0]  cnt_P0, cnt_P1, cnt_P2, cnt_P3, drop_cnt;
  logic              idle;
`ifdef PARITY_CHECK_EN
  logic              perr;
`endif

  route_demux #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .select(select),
    .pop_F0(pop[0]), .pop_F1(pop[1]), .pop_F2(pop[2]), .pop_F3(pop[3]),
    .data_F0(dat[0]), .data_F1(dat[1]), .data_F2(dat[2]), .data_F3(dat[3]),
    .almost_full_P0(af[0]), .almost_full_P1(af[1]),
    .almost_full_P2(af[2]), .almost_full_P3(af[3]),
    .push_P0(push_P0), .push_P1(push_P1), .push_P2(push_P2), .push_P3(push_P3),
    .data_out(data_out),
    .cnt_P0(cnt_P0), .cnt_P1(cnt_P1), .cnt_P2(cnt_P2), .cnt_P3(cnt_P3),
    .drop_cnt(drop_cnt), .idle(idle)
`ifdef PARITY_CHECK_EN
    , .perr(perr)
`endif
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: one pending word per cycle, counted at transaction level.
  int                exp_cnt [4];
  int                exp_drop;
  logic [3:0]        exp_push;
  logic [DATA_W-1:0] exp_data;
  logic              exp_idle;
  logic              exp_perr;
  logic              m_v;
  logic [1:0]        m_src;

  function automatic logic parity_bad(input logic [DATA_W-1:0] w);
`ifdef PARITY_CHECK_EN
    return ^w;
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [DATA_W-1:0] good_word(input logic [1:0] dest, input logic [31:0] rnd);
    logic [DATA_W-1:0] w;
    w    = {dest, rnd[6:0], 1'b0};
    w[0] = ^w[DATA_W-1:1];
    return w;
  endfunction

  function automatic logic [3:0] dut_push();
    return {push_P3, push_P2, push_P1, push_P0};
  endfunction

  function automatic logic [CNT_W-1:0] dut_cnt(input int i);
    case (i)
      0:       return cnt_P0;
      1:       return cnt_P1;
      2:       return cnt_P2;
      default: return cnt_P3;
    endcase
  endfunction

  function automatic logic dut_perr();
`ifdef PARITY_CHECK_EN
    return perr;
`else
    return 1'b0;
`endif
  endfunction

  // Applies one cycle of inputs (dat[] set by caller), advances the model, then steps the clock.
  task automatic cycle(input logic rst_v, input logic [3:0] pops, input logic [1:0] sel,
                       input logic [3:0] afv);
    logic [DATA_W-1:0] w;
    logic [1:0]        d;
    reset = rst_v; pop = pops; select = sel; af = afv;
    exp_push = '0;
    exp_perr = 1'b0;
    if (!rst_v) begin
      for (int i = 0; i < 4; i++) exp_cnt[i] = 0;
      exp_drop = 0;
      exp_data = '0;
      exp_idle = 1'b1;
      m_v      = 1'b0;
      m_src    = '0;
    end else begin
      if (m_v) begin
        w = dat[m_src];
        d = w[DATA_W-1:DATA_W-2];
        exp_perr = parity_bad(w);
        if (afv[d] || parity_bad(w)) begin
          if (exp_drop < CNT_MAX) exp_drop++;
        end else begin
          exp_push[d] = 1'b1;
          exp_data    = w;
          if (exp_cnt[d] < CNT_MAX) exp_cnt[d]++;
        end
      end
      exp_idle = !(|pops) && !m_v;
      m_v      = |pops;
      m_src    = sel;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 4; i++) dat[i] = '0;
    cycle(1'b0, 4'b0000, 2'd0, 4'b0000);
    cycle(1'b0, 4'b0000, 2'd0, 4'b0000);
    n_tests++;
    if (dut_push() !== 4'b0000 || idle !== 1'b1 || data_out !== '0 || drop_cnt !== '0) begin
      n_fail++;
      $display("FAIL reset_init: push=%b idle=%b data=%h drop=%0d, want 0000 1 000 0",
               dut_push(), idle, data_out, drop_cnt);
    end
    dat[1] = good_word(2'd2, 32'h15);
    cycle(1'b1, 4'b0010, 2'd1, 4'b0000);
    cycle(1'b1, 4'b0010, 2'd1, 4'b0000);
    cycle(1'b1, 4'b0010, 2'd1, 4'b0000);
    n_tests++;
    if (cnt_P2 !== 8'(exp_cnt[2]) || exp_cnt[2] != 2) begin
      n_fail++;
      $display("FAIL reset_pre_traffic: cnt_P2=%0d want %0d (model 2)", cnt_P2, exp_cnt[2]);
    end
    for (int k = 0; k < 2; k++) begin
      cycle(1'b0, 4'b0001, 2'd0, 4'b0000);
      n_tests++;
      if (dut_push() !== 4'b0000 || idle !== 1'b1 || cnt_P2 !== '0 || drop_cnt !== '0) begin
        n_fail++;
        $display("FAIL reset_mid_flight[%0d]: push=%b idle=%b cnt_P2=%0d drop=%0d, want 0000 1 0 0",
                 k, dut_push(), idle, cnt_P2, drop_cnt);
      end
    end
    dat[0] = good_word(2'd1, 32'h2A);
    cycle(1'b1, 4'b0001, 2'd0, 4'b0000);
    n_tests++;
    if (dut_push() !== 4'b0000 || idle !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release: push=%b idle=%b, want 0000 0", dut_push(), idle);
    end
    cycle(1'b1, 4'b0000, 2'd0, 4'b0000);
    n_tests++;
    if (dut_push() !== 4'b0010 || cnt_P1 !== 8'd1) begin
      n_fail++;
      $display("FAIL reset_after_release: push=%b cnt_P1=%0d, want 0010 1", dut_push(), cnt_P1);
    end
  endtask

  task automatic test_basic();
    cycle(1'b0, 4'b0000, 2'd0, 4'b0000);
    cycle(1'b1, 4'b0100, 2'd2, 4'b0000);
    n_tests++;
    if (dut_push() !== 4'b0000) begin
      n_fail++;
      $display("FAIL basic_one_edge: push=%b want 0000", dut_push());
    end
    dat[2] = 10'b01_0000_1010;
    cycle(1'b1, 4'b0000, 2'd0, 4'b0000);
    n_tests++;
    if (dut_push() !== exp_push || data_out !== exp_data || cnt_P1 !== 8'(exp_cnt[1])) begin
      n_fail++;
      $display("FAIL basic_push: push=%b data=%h cnt_P1=%0d, want %b %h %0d",
               dut_push(), data_out, cnt_P1, exp_push, exp_data, exp_cnt[1]);
    end
`ifndef PARITY_CHECK_EN
    n_tests++;
    if (dut_push() !== 4'b0010 || data_out !== 10'h10A || cnt_P1 !== 8'd1) begin
      n_fail++;
      $display("FAIL basic_const: push=%b data=%h cnt_P1=%0d, want 0010 10a 1",
               dut_push(), data_out, cnt_P1);
    end
`endif
    cycle(1'b1, 4'b0000, 2'd0, 4'b0000);
    n_tests++;
    if (dut_push() !== 4'b0000 || data_out !== exp_data || idle !== 1'b1) begin
      n_fail++;
      $display("FAIL basic_single_pulse: push=%b data=%h idle=%b, want 0000 %h 1",
               dut_push(), data_out, idle, exp_data);
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] want;
    cycle(1'b0, 4'b0000, 2'd0, 4'b0000);
    for (int k = 0; k < 5; k++) begin
      if (k > 0) dat[k-1] = good_word(2'(k-1), $urandom);
      cycle(1'b1, (k < 4) ? 4'(1 << k) : 4'b0000, 2'(k), 4'b0000);
      want = (k > 0) ? 4'(1 << (k-1)) : 4'b0000;
      n_tests++;
      if (dut_push() !== want || dut_push() !== exp_push) begin
        n_fail++;
        $display("FAIL b2b_push[%0d]: push=%b want %b", k, dut_push(), want);
      end
    end
    for (int i = 0; i < 4; i++) begin
      n_tests++;
      if (dut_cnt(i) !== 8'd1) begin
        n_fail++;
        $display("FAIL b2b_cnt[%0d]: got %0d want 1", i, dut_cnt(i));
      end
    end
  endtask

  task automatic test_drop();
    cycle(1'b0, 4'b0000, 2'd0, 4'b0000);
    cycle(1'b1, 4'b0010, 2'd1, 4'b0000);
    dat[1] = good_word(2'd3, $urandom);
    cycle(1'b1, 4'b0000, 2'd0, 4'b1000);
    n_tests++;
    if (dut_push() !== 4'b0000 || drop_cnt !== 8'd1 || cnt_P3 !== 8'd0) begin
      n_fail++;
      $display("FAIL drop_almost_full: push=%b drop=%0d cnt_P3=%0d, want 0000 1 0",
               dut_push(), drop_cnt, cnt_P3);
    end
  endtask

  task automatic test_saturate();
    cycle(1'b0, 4'b0000, 2'd0, 4'b0000);
    for (int k = 0; k < 302; k++) begin
      dat[0] = good_word(2'd0, $urandom);
      cycle(1'b1, (k < 300) ? 4'b0001 : 4'b0000, 2'd0, 4'b0000);
    end
    n_tests++;
    if (cnt_P0 !== 8'd255 || cnt_P0 !== 8'(exp_cnt[0])) begin
      n_fail++;
      $display("FAIL saturate_cnt_P0: got %0d want 255", cnt_P0);
    end
  endtask

  task automatic test_parity();
    cycle(1'b0, 4'b0000, 2'd0, 4'b0000);
    cycle(1'b1, 4'b1000, 2'd3, 4'b0000);
    dat[3] = good_word(2'd2, $urandom) ^ 10'h001;
    cycle(1'b1, 4'b0000, 2'd0, 4'b0000);
`ifdef PARITY_CHECK_EN
    n_tests++;
    if (dut_push() !== 4'b0000 || perr !== 1'b1 || drop_cnt !== 8'd1) begin
      n_fail++;
      $display("FAIL parity_bad_word: push=%b perr=%b drop=%0d, want 0000 1 1",
               dut_push(), perr, drop_cnt);
    end
    cycle(1'b1, 4'b0000, 2'd0, 4'b0000);
    n_tests++;
    if (perr !== 1'b0) begin
      n_fail++;
      $display("FAIL parity_perr_pulse: perr=%b want 0", perr);
    end
`else
    n_tests++;
    if (dut_push() !== 4'b0100 || drop_cnt !== 8'd0 || data_out !== dat[3]) begin
      n_fail++;
      $display("FAIL parity_off_push: push=%b drop=%0d data=%h, want 0100 0 %h",
               dut_push(), drop_cnt, data_out, dat[3]);
    end
`endif
  endtask

  task automatic test_random();
    logic [3:0] pv;
    logic [1:0] sel;
    logic       rst_v;
    int         r;
    cycle(1'b0, 4'b0000, 2'd0, 4'b0000);
    for (int k = 0; k < 600; k++) begin
      for (int i = 0; i < 4; i++) dat[i] = DATA_W'($urandom);
      sel   = 2'($urandom_range(0, 3));
      rst_v = ($urandom_range(0, 59) != 0);
      r     = $urandom_range(0, 9);
      if (r < 6)       pv = 4'(1 << sel);
      else if (r == 6) pv = 4'($urandom) | 4'(1 << sel);
      else             pv = 4'b0000;
      cycle(rst_v, pv, sel, ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000);
      n_tests++;
      if (dut_push() !== exp_push || data_out !== exp_data || drop_cnt !== 8'(exp_drop) ||
          idle !== exp_idle || dut_perr() !== exp_perr) begin
        n_fail++;
        $display("FAIL random[%0d]: push=%b data=%h drop=%0d idle=%b perr=%b, want %b %h %0d %b %b",
                 k, dut_push(), data_out, drop_cnt, idle, dut_perr(),
                 exp_push, exp_data, exp_drop, exp_idle, exp_perr);
      end
      for (int i = 0; i < 4; i++) begin
        n_tests++;
        if (dut_cnt(i) !== 8'(exp_cnt[i])) begin
          n_fail++;
          $display("FAIL random_cnt[%0d][%0d]: got %0d want %0d", k, i, dut_cnt(i), exp_cnt[i]);
        end
      end
    end
  endtask

  initial begin
    m_v = 1'b0; m_src = '0; exp_drop = 0;
    for (int i = 0; i < 4; i++) exp_cnt[i] = 0;
    test_reset();
    test_basic();
    test_back_to_back();
    test_drop();
    test_saturate();
    test_parity();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
